// File: rtl/credit_sender.sv
// credit_sender: queues upstream words and forwards them to a dual-clock buffer,
// sending only while the buffer's reported free slots exceed writes still in flight.
module credit_sender #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int QDEPTH     = 4,
  parameter int CREDIT_LAT = 2
) (
  input  logic                      re_clk,
  input  logic                      re_reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [ADDR_W:0]           re_credit,
  output logic                      re_valid,
  output logic [WIDTH-1:0]          re_data,
  output logic [1:0]                state,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic [15:0]               stall_count
);
  localparam int PW = $clog2(QDEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, STALL = 2'd2} state_t;
  logic [WIDTH-1:0]      mem [QDEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CREDIT_LAT-1:0] hist;
  logic [ADDR_W:0]       inflight;
  logic                  armed, push, send;
  state_t                st;
  // armed keeps in_ready low until the first edge after reset release
  assign in_ready = armed && (q_count < (PW+1)'(QDEPTH));
  assign push     = in_valid && in_ready;
  assign send     = (q_count != '0) && (re_credit > inflight);
  assign re_valid = send;
  assign re_data  = send ? mem[rptr] : '0;
  assign st       = (q_count == '0) ? IDLE : send ? SEND : STALL;
  assign state    = st;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CREDIT_LAT; i++) inflight = inflight + (ADDR_W+1)'(hist[i]);
  end
  always_ff @(posedge re_clk or negedge re_reset_n) begin
    if (!re_reset_n) begin
      armed       <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      q_count     <= '0;
      hist        <= '0;
      stall_count <= '0;
    end else begin
      armed   <= 1'b1;
      hist    <= CREDIT_LAT'({hist, send});
      q_count <= q_count + (PW+1)'(push) - (PW+1)'(send);
      if (push) wptr <= wptr + 1'b1;
      if (send) rptr <= rptr + 1'b1;
      if (st == STALL && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
  always_ff @(posedge re_clk) begin
    if (push) mem[wptr] <= in_data;
  end
endmodule

// File: tb/tb_credit_sender.sv
// tb_credit_sender: directed checks of credit_sender plus a randomized downstream-buffer run.
module tb_credit_sender;
  localparam int WIDTH = 32, DEPTH = 16, AW = 4, QDEPTH = 4, CL = 2;
  logic              re_clk = 1'b0, re_reset_n = 1'b0, in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic [AW:0]       re_credit = '0;
  logic              in_ready, re_valid;
  logic [WIDTH-1:0]  re_data;
  logic [1:0]        state;
  logic [2:0]        q_count;
  logic [15:0]       stall_count;
  int checks = 0, errors = 0;

  credit_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH), .QDEPTH(QDEPTH), .CREDIT_LAT(CL)) dut (
    .re_clk(re_clk), .re_reset_n(re_reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .re_credit(re_credit), .re_valid(re_valid), .re_data(re_data),
    .state(state), .q_count(q_count), .stall_count(stall_count));

  always #5 re_clk = ~re_clk;

  task automatic step();
    @(posedge re_clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    re_credit = '0;
    re_reset_n = 1'b0;
    #2;
    step();
    re_reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    re_reset_n = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h55;
    re_credit = 5'd16;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_q_count: got %0d expected 0", q_count); end
    checks++; if (re_valid !== 1'b0) begin errors++; $display("FAIL reset_re_valid: got %0b expected 0", re_valid); end
    checks++; if (re_data !== 32'h0) begin errors++; $display("FAIL reset_re_data: got %0h expected 0", re_data); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall_count); end
    step();
    step();
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_no_push: got %0d expected 0", q_count); end
    re_reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_before_edge: got %0b expected 0", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_after_edge: got %0b expected 1", in_ready); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL release_q_count: got %0d expected 0", q_count); end
  endtask

  task automatic test_stall();
    do_reset();
    re_credit = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 32'hA0 + i;
      step();
    end
    in_data = 32'hFF;
    #1;
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL stall_q_full: got %0d expected 4", q_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL stall_state: got %0d expected 2", state); end
    checks++; if (re_valid !== 1'b0) begin errors++; $display("FAIL stall_re_valid: got %0b expected 0", re_valid); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL stall_count_3: got %0d expected 3", stall_count); end
    repeat (5) step();
    checks++; if (stall_count !== 16'd8) begin errors++; $display("FAIL stall_count_8: got %0d expected 8", stall_count); end
    checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL stall_no_overfill: got %0d expected 4", q_count); end
    re_credit = 5'd16;
    #1;
    checks++; if (re_valid !== 1'b1) begin errors++; $display("FAIL full_pop_valid: got %0b expected 1", re_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %0b expected 0", in_ready); end
    checks++; if (re_data !== 32'hA0) begin errors++; $display("FAIL full_head: got %0h expected a0", re_data); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL full_state_send: got %0d expected 1", state); end
    in_valid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (re_valid !== 1'b1 || re_data !== 32'hA0 + k)
        begin errors++; $display("FAIL drain_word%0d: got v=%0b d=%0h expected v=1 d=%0h", k, re_valid, re_data, 32'hA0 + k); end
    end
    step();
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL drain_empty: got %0d expected 0", q_count); end
    checks++; if (re_valid !== 1'b0 || re_data !== 32'h0) begin errors++; $display("FAIL idle_outputs: got v=%0b d=%0h expected v=0 d=0", re_valid, re_data); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d expected 0", state); end
    checks++; if (stall_count !== 16'd8) begin errors++; $display("FAIL stall_hold: got %0d expected 8", stall_count); end
  endtask

  task automatic test_stream();
    do_reset();
    re_credit = 5'd16;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = 100 + k;
      #1;
      if (k == 0) begin
        checks++; if (re_valid !== 1'b0) begin errors++; $display("FAIL stream_no_bypass: got %0b expected 0", re_valid); end
      end else begin
        checks++; if (re_valid !== 1'b1 || re_data !== 32'(100 + k - 1))
          begin errors++; $display("FAIL stream_word%0d: got v=%0b d=%0d expected v=1 d=%0d", k, re_valid, re_data, 100 + k - 1); end
        checks++; if (q_count !== 3'd1) begin errors++; $display("FAIL stream_q%0d: got %0d expected 1", k, q_count); end
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (re_valid !== 1'b1 || re_data !== 32'd107) begin errors++; $display("FAIL stream_last: got v=%0b d=%0d expected v=1 d=107", re_valid, re_data); end
    step();
    checks++; if (q_count !== 3'd0 || re_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got q=%0d v=%0b expected q=0 v=0", q_count, re_valid); end
  endtask

  task automatic test_credit_one();
    do_reset();
    re_credit = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 32'hB0 + i;
      step();
    end
    in_valid = 1'b0;
    step();
    re_credit = 5'd1;
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++; if (re_valid !== (c % 3 == 0))
        begin errors++; $display("FAIL credit1_cycle%0d: got %0b expected %0b", c, re_valid, (c % 3 == 0)); end
      if (c % 3 == 0) begin
        checks++; if (re_data !== 32'hB0 + c / 3)
          begin errors++; $display("FAIL credit1_data%0d: got %0h expected %0h", c, re_data, 32'hB0 + c / 3); end
      end
      step();
    end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL credit1_empty: got %0d expected 0", q_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    re_credit = '0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 32'hC0 + i;
      step();
    end
    in_valid = 1'b0;
    checks++; if (q_count !== 3'd3 || stall_count !== 16'd2)
      begin errors++; $display("FAIL mid_pre: got q=%0d s=%0d expected q=3 s=2", q_count, stall_count); end
    re_credit = 5'd16;
    #1;
    checks++; if (re_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b expected 1", re_valid); end
    #1;
    re_reset_n = 1'b0;
    #1;
    checks++; if (re_valid !== 1'b0) begin errors++; $display("FAIL mid_re_valid: got %0b expected 0", re_valid); end
    checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL mid_q_count: got %0d expected 0", q_count); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mid_stall: got %0d expected 0", stall_count); end
    checks++; if (in_ready !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL mid_ready_state: got r=%0b st=%0d expected r=0 st=0", in_ready, state); end
    step();
    re_reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (re_valid !== 1'b0 || q_count !== 3'd0)
        begin errors++; $display("FAIL mid_after%0d: got v=%0b q=%0d expected v=0 q=0", c, re_valid, q_count); end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    re_credit = '0;
    in_valid = 1'b1;
    in_data = 32'hD0;
    step();
    in_valid = 1'b0;
    repeat (65534) step();
    checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %0h expected fffe", stall_count); end
    step();
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %0h expected ffff", stall_count); end
    repeat (10) step();
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffff", stall_count); end
    checks++; if (state !== 2'd2 || q_count !== 3'd1) begin errors++; $display("FAIL sat_state: got st=%0d q=%0d expected st=2 q=1", state, q_count); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_q[$];
    logic [CL-1:0] th;
    int occ, pushed, received, cr, cnt;
    logic v, drain;
    do_reset();
    th = '0; occ = 0; pushed = 0; received = 0;
    re_credit = 5'(DEPTH);
    for (int cyc = 0; cyc < 3000 && received < 40; cyc++) begin
      in_valid = (pushed < 40) && ($urandom % 4 != 0);
      in_data = $urandom;
      #1;
      if (re_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rand_dup: got %0h expected no word", re_data); end
        else begin
          if (re_data !== exp_q[0]) begin errors++; $display("FAIL rand_order%0d: got %0h expected %0h", received, re_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        received++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(in_data); pushed++; end
      drain = (occ > 0) && ($urandom % 3 == 0);
      v = re_valid;
      step();
      occ = occ + int'(v) - int'(drain);
      th = {th[0], v};
      cnt = int'(th[0]) + int'(th[1]);
      if (occ > DEPTH) begin checks++; errors++; $display("FAIL rand_overflow: got occupancy %0d expected <= %0d", occ, DEPTH); end
      cr = DEPTH - occ + cnt;
      if (cr > DEPTH) cr = DEPTH;
      re_credit = 5'(cr);
    end
    checks++; if (received !== 40) begin errors++; $display("FAIL rand_count: got %0d expected 40", received); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_stream();
    test_credit_one();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/credit_sender.md
CREDIT_SENDER -- requirements
Module: credit_sender

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width (matches the downstream dual-clock buffer).
REQ-002 SHALL have parameter DEPTH, default 16, meaning downstream buffer depth; ADDR_W, default $clog2(DEPTH), meaning pointer width.
REQ-003 SHALL have parameter QDEPTH, default 4, meaning local queue entries (power of 2, >=2).
REQ-004 SHALL have parameter CREDIT_LAT, default 2, meaning cycles before a sent write is reflected in re_credit.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 re_clk  in  1  write-domain clock; all state on rising edge.
REQ-007 re_reset_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  upstream word valid.
REQ-009 in_ready  out  1  queue can accept a word.
REQ-010 in_data  in  WIDTH  upstream word.
REQ-011 re_credit  in  ADDR_W+1  free slots reported by downstream buffer.
REQ-012 re_valid  out  1  write strobe to downstream buffer.
REQ-013 re_data  out  WIDTH  word to downstream buffer data_in.
REQ-014 state  out  2  0=IDLE, 1=SEND, 2=STALL; 3 never driven.
REQ-015 q_count  out  $clog2(QDEPTH)+1  current queue occupancy.
REQ-016 stall_count  out  16  saturating count of STALL cycles.

Function
REQ-017 Push on rising edge when in_valid && in_ready; in_ready = (q_count < QDEPTH), combinational.
REQ-018 When full, in_ready SHALL be 0 even if a pop occurs the same cycle (no full-bypass).
REQ-019 No input-to-output bypass: word pushed at edge N SHALL appear on re_data no earlier than cycle after edge N.
REQ-020 inflight = number of 1s in a CREDIT_LAT-bit history register; history shifts in the send bit every edge.
REQ-021 send = (q_count != 0) && (re_credit > inflight), combinational; re_valid = send.
REQ-022 re_data = queue head when re_valid=1, else all zeros.
REQ-023 On edge with send=1 the head SHALL pop; simultaneous push and pop leaves q_count unchanged.
REQ-024 Queue pointers SHALL wrap modulo QDEPTH; words leave in strict push order.
REQ-025 re_credit compare SHALL be unsigned, width ADDR_W+1; inflight zero-extended to the same width.
REQ-026 state = IDLE when q_count==0; SEND when send=1; STALL when q_count!=0 && send=0 (combinational).
REQ-027 stall_count increments by 1 on each edge where state==STALL; holds at 16'hFFFF.
REQ-028 At most one word sent per cycle; re_valid=1 implies re_credit != 0.

Reset
REQ-029 re_reset_n=0 SHALL asynchronously force q_count=0, pointers=0, history=0, stall_count=0, re_valid=0, re_data=0, state=IDLE.
REQ-030 in_ready SHALL be 0 while re_reset_n=0 and 1 from the first edge after deassertion.
REQ-031 Reset mid-operation SHALL discard queued words; none are sent after release.
REQ-032 Reset deassertion SHALL be treated as synchronous to re_clk by the integrator.

Verification
REQ-033 Reset mid-traffic: q_count=3, pull re_reset_n low between edges -> re_valid, q_count, stall_count = 0 immediately, no later sends.
REQ-034 re_credit=0, push 4 words back-to-back -> in_ready=0 after 4th, state=STALL, re_valid=0, stall_count=N after N edges.
REQ-035 re_credit=16 constant, continuous in_valid -> re_valid high every cycle from 2nd cycle, words in order, q_count stays <=1.
REQ-036 re_credit=1 constant, CREDIT_LAT=2, queue holding 3 words -> sends at cycles 0, 3, 6 only.
REQ-037 re_credit=0 for 70000 cycles with queue non-empty -> stall_count=16'hFFFF and holds.
REQ-038 Integrated with the dual-clock buffer (10 ns write, 15 ns read clock), 40 random words with random te_ready -> no drop, no duplicate, order preserved.
